// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational instruction
// memory and captures the returned word into the IF/ID pipeline register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] IMemAddress,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [31:0] FetchCount
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_next_seq;

    // Wraps naturally at 2^32, so FFFF_FFFC advances to 0000_0000.
    assign pc_next_seq = pc_q + PC_INC;

    // Redirect beats Stall: the word fetched at the old PC is dropped and a
    // bubble is inserted, leaving FetchCount untouched.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (Redirect) begin
            pc_d    = {RedirectTarget[31:2], 2'b00};
            instr_d = NOP_WORD;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (!Stall) begin
            pc_d    = pc_next_seq;
            instr_d = IMemInstruction;
            pcp4_d  = pc_next_seq;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign IMemAddress       = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pcp4_q;
    assign IF_ID_Valid       = valid_q;
    assign FetchCount        = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word i holds i*3.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] IMemInstruction;
    logic [31:0] IMemAddress;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [31:0] FetchCount;

    logic [31:0] mem [1024];
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 Clk = ~Clk;

    assign IMemInstruction = mem[IMemAddress[11:2]];

    instruction_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(32'h0000_0000),
        .PC_INC  (32'd4)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectTarget   (RedirectTarget),
        .IMemInstruction  (IMemInstruction),
        .IMemAddress      (IMemAddress),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4    (IF_ID_PCPlus4),
        .IF_ID_Valid      (IF_ID_Valid),
        .FetchCount       (FetchCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pcp4, input logic valid, input logic [31:0] cnt);
        check({tag, ".pc"}, IMemAddress, pc);
        check({tag, ".instr"}, IF_ID_Instruction, instr);
        check({tag, ".pcp4"}, IF_ID_PCPlus4, pcp4);
        check({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, valid});
        check({tag, ".count"}, FetchCount, cnt);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int unsigned i = 0; i < 1024; i++) mem[i] = i * 3;
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = '0;
        #1;

        // Reset held for two edges
        tick(); tick();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        // Sequential fetch
        Reset = 1'b1;
        tick(); check_all("seq1", 32'h4, 32'd0, 32'h4, 1'b1, 32'd1);
        tick(); check_all("seq2", 32'h8, 32'd3, 32'h8, 1'b1, 32'd2);

        // Stall three cycles at PC=8
        Stall = 1'b1;
        tick(); check_all("stall1", 32'h8, 32'd3, 32'h8, 1'b1, 32'd2);
        tick(); check_all("stall2", 32'h8, 32'd3, 32'h8, 1'b1, 32'd2);
        tick(); check_all("stall3", 32'h8, 32'd3, 32'h8, 1'b1, 32'd2);
        Stall = 1'b0;
        tick(); check_all("unstall", 32'hC, 32'd6, 32'hC, 1'b1, 32'd3);

        // Redirect to 0x40 from PC=12
        Redirect = 1'b1; RedirectTarget = 32'h40;
        tick(); check_all("redir", 32'h40, 32'd0, 32'h0, 1'b0, 32'd3);
        Redirect = 1'b0;
        tick(); check_all("redir_tgt", 32'h44, 32'd48, 32'h44, 1'b1, 32'd4);

        // Redirect with stall, unaligned target; then stall holds the bubble
        Redirect = 1'b1; Stall = 1'b1; RedirectTarget = 32'h23;
        tick(); check_all("redir_stall", 32'h20, 32'd0, 32'h0, 1'b0, 32'd4);
        Redirect = 1'b0;
        tick(); check_all("bubble_hold", 32'h20, 32'd0, 32'h0, 1'b0, 32'd4);
        Stall = 1'b0;
        tick(); check_all("after_bubble", 32'h24, 32'd24, 32'h24, 1'b1, 32'd5);

        // PC wrap at top of address space
        Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFC;
        tick(); check_all("wrap_redir", 32'hFFFF_FFFC, 32'd0, 32'h0, 1'b0, 32'd5);
        Redirect = 1'b0;
        tick(); check_all("wrap1", 32'h0, 32'd3069, 32'h0, 1'b1, 32'd6);
        tick(); check_all("wrap2", 32'h4, 32'd0, 32'h4, 1'b1, 32'd7);

        // Address aliasing: 0x1004 reads word 1
        Redirect = 1'b1; RedirectTarget = 32'h1004;
        tick(); check_all("alias_redir", 32'h1004, 32'd0, 32'h0, 1'b0, 32'd7);
        Redirect = 1'b0;
        tick(); check_all("alias", 32'h1008, 32'd3, 32'h1008, 1'b1, 32'd8);

        // Reset during stall and redirect at PC=0x80
        Redirect = 1'b1; RedirectTarget = 32'h80;
        tick(); check_all("to80", 32'h80, 32'd0, 32'h0, 1'b0, 32'd8);
        Reset = 1'b0; Stall = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h100;
        tick(); check_all("reset_mid", 32'h0, 32'd0, 32'h0, 1'b0, 32'd0);
        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0;
        tick(); check_all("post_reset", 32'h4, 32'd0, 32'h4, 1'b1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-fetch interface: owns the program counter and drives a word address into the combinational instruction memory.
- Instruction memory: 1024 words, indexed by Address[11:2], read data valid in the same cycle.
- Captures the returned word into the IF/ID pipeline register and handles stall, branch/jump redirect and flush.
- Keeps a count of retired fetches for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_WORD, 32'h0000_0000, instruction injected into IF/ID on flush or reset (sll $0,$0,0).
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset, input, 1, synchronous, active-low; sampled on rising Clk.
- Stall, input, 1, hold PC and IF/ID contents (load-use hazard).
- Redirect, input, 1, taken branch/jump this cycle.
- RedirectTarget, input, 32, byte address of new PC.
- IMemInstruction, input, 32, word returned by instruction memory for IMemAddress.
- IMemAddress, output, 32, current PC, driven to instruction memory Address.
- IF_ID_Instruction, output, 32, registered fetched instruction.
- IF_ID_PCPlus4, output, 32, registered PC+4 of that instruction.
- IF_ID_Valid, output, 1, 1 = IF/ID holds a real fetched instruction; 0 = bubble.
- FetchCount, output, 32, number of instructions latched with IF_ID_Valid=1 since reset.

Behaviour:
- IMemAddress = PC register (combinational from register, no extra latency).
- Reset (Reset==0 at rising Clk):
  - PC <= RESET_PC; IF_ID_Instruction <= NOP_WORD; IF_ID_PCPlus4 <= 0; IF_ID_Valid <= 0; FetchCount <= 0.
  - Reset overrides all other inputs, including mid-stall or mid-redirect.
- Priority per cycle (Reset high): Redirect > Stall > normal.
- Normal (Redirect=0, Stall=0):
  - PC <= PC + PC_INC.
  - IF_ID_Instruction <= IMemInstruction; IF_ID_PCPlus4 <= PC + PC_INC; IF_ID_Valid <= 1.
  - FetchCount <= FetchCount + 1.
- Stall (Redirect=0, Stall=1): PC, all IF_ID_* and FetchCount hold. Same address stays on IMemAddress.
- Redirect (Redirect=1, regardless of Stall):
  - PC <= {RedirectTarget[31:2], 2'b00}; target low bits are silently cleared.
  - IF/ID flushed: IF_ID_Instruction <= NOP_WORD; IF_ID_Valid <= 0; IF_ID_PCPlus4 <= 0.
  - FetchCount holds.
  - The word fetched at the old PC in that cycle is discarded.
- Latency:
  - Instruction at address A appears on IF_ID_Instruction one cycle after PC==A with no stall.
  - After redirect, the target instruction appears in IF/ID two edges after Redirect is sampled (one bubble).
- Arithmetic:
  - PC + PC_INC is 32-bit unsigned, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
  - Instruction memory uses only Address[11:2], so PC 32'h0000_1000 aliases word 0; no error is flagged.
  - FetchCount wraps at 2^32 - 1 -> 0.
- Effectively a two-state control, per cycle: RUN (normal or stall) and FLUSH (cycle after redirect, IF_ID_Valid=0). The cycle after FLUSH with Stall=0 returns to RUN with a valid fetch. A Stall during that cycle holds the bubble.
- No combinational path from any input to IMemAddress.

Test Plan:
- Reset low for 2 cycles, then high with memory[i]=i*3 → IMemAddress 0,4,8,12 on successive cycles; IF_ID_Instruction 0,3,6 starting the cycle after release; IF_ID_PCPlus4 4,8,12; FetchCount 1,2,3.
- Stall=1 for 3 cycles at PC=8 → IMemAddress stays 8; IF_ID_Instruction stays 3; FetchCount constant; after release, IF_ID_Instruction=6 and PC=12.
- Redirect=1, RedirectTarget=32'h40 at PC=12 → next cycle IMemAddress=32'h40, IF_ID_Valid=0, IF_ID_Instruction=0; following cycle IF_ID_Instruction=48 (word 16), IF_ID_PCPlus4=32'h44, IF_ID_Valid=1.
- Redirect=1 and Stall=1 together, target 32'h23 → PC becomes 32'h20 (low bits cleared); IF/ID flushed; FetchCount unchanged.
- Redirect to 32'hFFFF_FFFC, then run 2 cycles → IMemAddress FFFF_FFFC then 0000_0000; IF_ID_Instruction = memory[1023]*; IF_ID_PCPlus4 = 0.
- Reset low asserted during a stall and redirect at PC=32'h80 → next edge PC=RESET_PC, IF_ID_Valid=0, FetchCount=0.

*memory[1023] = 3069.
